// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op selects, FSM encodings, funct7 constants and the decoded-request struct
// for alu_exec_unit and alu_muldiv_iter.
package alu_pkg;

  localparam int ALUSEL_WIDTH = 4;
  typedef logic [ALUSEL_WIDTH-1:0] alu_sel_t;

  localparam alu_sel_t ALU_ADD    = 4'd0;
  localparam alu_sel_t ALU_SUB    = 4'd1;
  localparam alu_sel_t ALU_SLL    = 4'd2;
  localparam alu_sel_t ALU_SLT    = 4'd3;
  localparam alu_sel_t ALU_SLTU   = 4'd4;
  localparam alu_sel_t ALU_XOR    = 4'd5;
  localparam alu_sel_t ALU_SRL    = 4'd6;
  localparam alu_sel_t ALU_SRA    = 4'd7;
  localparam alu_sel_t ALU_OR     = 4'd8;
  localparam alu_sel_t ALU_AND    = 4'd9;
  localparam alu_sel_t ALU_MULDIV = 4'd10;
  localparam alu_sel_t ALU_NOP    = 4'd11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    alu_sel_t sel;
    logic     illegal;
    logic     muldiv;
  } dec_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: XLEN-step shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied to the final step's combinational result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  logic            is_div,
  input  logic            sign_a,
  input  logic            sign_b,
  input  logic            want_hi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, q, d;
  logic            div_r, hi_r, neg_res, neg_rem, div0;

  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign neg_a = sign_a & a[XLEN-1];
  assign neg_b = sign_b & b[XLEN-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  logic [XLEN:0]     sum, trial, diff;
  logic              ge;
  logic [XLEN-1:0]   acc_n, q_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  always_comb begin
    sum   = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    trial = {acc, q[XLEN-1]};
    diff  = trial - {1'b0, d};
    ge    = (trial >= {1'b0, d});
    if (div_r) begin
      // the partial remainder stays below the divisor, so XLEN bits hold it
      acc_n = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
      q_n   = {q[XLEN-2:0], ge};
    end else begin
      acc_n = sum[XLEN:1];
      q_n   = {sum[0], q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {acc_n, q_n};
    prod_s = neg_res ? -prod : prod;
    quot_s = div0 ? '1 : (neg_res ? -q_n : q_n);
    rem_s  = neg_rem ? -acc_n : acc_n;
    if (div_r) result = hi_r ? rem_s : quot_s;
    else       result = hi_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  assign done = busy & (cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      q       <= '0;
      d       <= '0;
      div_r   <= 1'b0;
      hi_r    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      q       <= is_div ? mag_a : mag_b;
      d       <= is_div ? mag_b : mag_a;
      div_r   <= is_div;
      hi_r    <= want_hi;
      neg_res <= neg_a ^ neg_b;
      neg_rem <= neg_a;
      div0    <= is_div & (b == '0);
    end else if (busy) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked RV32-style execute unit; base ops complete in one cycle.
// Define ALU_MULDIV_EN to decode funct7=0000001 and add the iterative alu_muldiv_iter engine.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUSEL_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_t state;
  dec_t   dec;
  logic   accept;

  always_comb begin
    dec = '{sel: ALU_ADD, illegal: 1'b0, muldiv: 1'b0};
    case (alu_op)
      2'b00: dec.sel = ALU_ADD;
      2'b01: dec.sel = ALU_SUB;
      2'b10: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          case (funct3)
            3'b000:  dec.sel = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  dec.sel = ALU_SLL;
            3'b010:  dec.sel = ALU_SLT;
            3'b011:  dec.sel = ALU_SLTU;
            3'b100:  dec.sel = ALU_XOR;
            3'b101:  dec.sel = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec.sel = ALU_OR;
            default: dec.sel = ALU_AND;
          endcase
`ifdef ALU_MULDIV_EN
        end else if (funct7 == F7_MULDIV) begin
          dec.sel    = ALU_MULDIV;
          dec.muldiv = 1'b1;
`endif
        end else begin
          dec.sel     = ALU_NOP;
          dec.illegal = 1'b1;
        end
      end
      default: begin
        dec.sel     = ALU_NOP;
        dec.illegal = 1'b1;
      end
    endcase
  end

  logic [ALUSEL_W-1:0] sel;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     alu_res, base_res;

  assign sel   = dec.sel;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    case (sel)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  assign base_res = dec.illegal ? '0 : alu_res;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  // a request seen together with flush is dropped, not queued
  assign accept   = in_valid & in_ready & ~flush;

  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;

`ifdef ALU_MULDIV_EN
  logic md_sign_a, md_sign_b, md_want_hi;

  // funct3[2] splits mul/div; funct3[0] marks the unsigned divide variants
  assign md_sign_a  = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign md_sign_b  = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign md_want_hi = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .kill    (flush),
    .start   (accept & dec.muldiv),
    .is_div  (funct3[2]),
    .sign_a  (md_sign_a),
    .sign_b  (md_sign_b),
    .want_hi (md_want_hi),
    .a       (op_a),
    .b       (op_b),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_result)
  );
`else
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (dec.muldiv) begin
              state     <= CALC;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= base_res;
              zero      <= (base_res == '0);
              illegal   <= dec.illegal;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CALC: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= md_result;
            zero      <= (md_result == '0);
            illegal   <= 1'b0;
          end else if (!md_busy) begin
            // engine lost its operation; never leave the unit stuck in CALC
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed steps plus randomized traffic scored against a plain-arithmetic
// model with per-result ready times. Build with ALU_MULDIV_EN to cover the M-extension.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            in_valid = 1'b0, in_ready, flush = 1'b0;
  logic            out_valid, out_ready = 1'b1, zero, illegal;
  logic [1:0]      alu_op = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic [6:0]      funct7 = 7'h00;
  logic [XLEN-1:0] op_a = '0, op_b = '0, result;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .ALUSEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          t;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Reference: RV32I/M arithmetic computed directly from the instruction fields.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int sa, sbv, sh;
    longint p;
    logic [63:0] up;
    r = 32'h0; ill = 1'b0; lat = 1;
    sa = $signed(a); sbv = $signed(b); sh = int'(b[4:0]);
    p = 0; up = 64'h0;
    if (op == 2'b11) ill = 1'b1;
    else if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sbv) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) r = sa >>> sh;
`ifdef ALU_MULDIV_EN
    else if (f7 == 7'h01) begin
      lat = XLEN + 1;
      case (f3)
        3'd0: begin p = longint'(sa) * longint'(sbv); r = p[31:0]; end
        3'd1: begin p = longint'(sa) * longint'(sbv); r = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
        3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sbv);
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sbv);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
`endif
    else ill = 1'b1;
  endfunction

  initial begin
    logic [31:0] r;
    logic        ill, exp_v, seen;
    int          lat;

    // reset held
    repeat (3) step();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk ("rst_result", result, 32'h0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("rst_in_ready", in_ready, 1'b1);

    // R-type SUB 5-7
    set_req(2'b10, 3'b000, 7'h20, 32'd5, 32'd7);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk1("sub_valid", out_valid, 1'b1);
    chk ("sub_result", result, 32'hFFFF_FFFE);
    chk1("sub_zero", zero, 1'b0);
    chk1("sub_illegal", illegal, 1'b0);
    step();
    chk1("sub_drained", out_valid, 1'b0);

    // branch compare equal, then backpressure
    out_ready = 1'b0;
    set_req(2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("hold_valid", out_valid, 1'b1);
      chk ("hold_result", result, 32'h0);
      chk1("hold_zero", zero, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1; #1;
    chk1("release_in_ready", in_ready, 1'b1);
    step();
    chk1("release_drained", out_valid, 1'b0);

    // illegal funct7 and reserved alu_op
    set_req(2'b10, 3'b000, 7'h7F, 32'd9, 32'd9);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk1("ill_valid", out_valid, 1'b1);
    chk ("ill_result", result, 32'h0);
    chk1("ill_flag", illegal, 1'b1);
    set_req(2'b11, 3'b000, 7'h00, 32'd3, 32'd4);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk1("rsv_flag", illegal, 1'b1);
    chk ("rsv_result", result, 32'h0);
    step();

    // request coincident with flush is dropped
    set_req(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    in_valid = 1'b1; flush = 1'b1; step(); in_valid = 1'b0; flush = 1'b0;
    chk1("flush_drop_valid", out_valid, 1'b0);
    chk1("flush_drop_ready", in_ready, 1'b1);

    // asynchronous reset while a result is pending
    set_req(2'b00, 3'b000, 7'h00, 32'd3, 32'd4);
    out_ready = 1'b0;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk ("pre_rst_result", result, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk ("async_rst_result", result, 32'h0);
    step(); rst_n = 1'b1; out_ready = 1'b1; step();
    chk1("post_rst_ready", in_ready, 1'b1);

`ifdef ALU_MULDIV_EN
    // DIV signed overflow
    set_req(2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    chk ("div_ovf_latency", 32'(lat), 32'd33);
    chk ("div_ovf_result", result, 32'h8000_0000);
    step();

    // DIVU by zero
    set_req(2'b10, 3'b101, 7'h01, 32'h1234_5678, 32'h0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    chk ("divu0_latency", 32'(lat), 32'd33);
    chk ("divu0_result", result, 32'hFFFF_FFFF);
    step();

    // MUL killed by flush mid-iteration
    set_req(2'b10, 3'b000, 7'h01, 32'd6, 32'd7);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1; step(); flush = 1'b0;
    chk1("mul_flush_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin seen |= out_valid; step(); end
    chk1("mul_flush_no_valid", seen, 1'b0);
    set_req(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk1("post_flush_valid", out_valid, 1'b1);
    chk ("post_flush_add", result, 32'd2);
    step();
`endif

    // randomized traffic with backpressure and occasional flush
    sb.delete();
    for (int n = 0; n < 600; n++) begin
      logic [1:0] op;
      logic [6:0] f7;
      op = ($urandom_range(0, 5) < 4) ? 2'b10 : 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: f7 = 7'h00;
        5, 6:          f7 = 7'h20;
        7:             f7 = 7'h01;
        8:             f7 = 7'h7F;
        default:       f7 = 7'($urandom);
      endcase
      set_req(op, 3'($urandom), f7, rnd_operand(), rnd_operand());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      exp_v = (sb.size() > 0) ? (cyc >= sb[0].t) : 1'b0;
      chk1("rnd_out_valid", out_valid, exp_v);
      chk1("rnd_in_ready", in_ready, (sb.size() == 0) || (exp_v && out_ready));
      if (exp_v && out_ready && !flush) begin
        chk ("rnd_result", result, sb[0].res);
        chk1("rnd_illegal", illegal, sb[0].ill);
        chk1("rnd_zero", zero, sb[0].res == 32'h0);
        void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        model(alu_op, funct3, funct7, op_a, op_b, r, ill, lat);
        sb.push_back('{res: r, ill: ill, t: cyc + lat});
      end
      step();
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
